serial_frame_tx: RTL and testbench
==================================

// Module: serial_frame_tx
// PURPOSE
//   Serial bitstream transmitter: accepts a parallel word over a valid/ready handshake and
//   emits it on a 1-bit line as a framed sequence (preamble, data MSB-first, optional even
//   parity, stop, idle gap). It is the sending end of the single-bit serial links that the
//   Moore-style bit-pattern detectors in this design consume. Clean Moore FSM; out is a
//   function of registered state only.
// PARAMETERS
//   DATA_W        8   payload width in bits (>=1)
//   PREAMBLE_LEN  2   number of '1' preamble bits before data (>=1)
//   PARITY_EN     1   1: append even-parity bit after data; 0: no parity bit
//   IDLE_GAP      1   number of forced '0' gap cycles after stop, in_ready low (>=0)
// PORTS
//   clk       in   1       clock, all logic on rising edge
//   rst       in   1       synchronous reset, active-high
//   in_valid  in   1       producer has a word on in_data
//   in_data   in   DATA_W  word to send; sampled only on handshake
//   in_ready  out  1       transmitter can accept a word (high only in IDLE)
//   out       out  1       serial line
//   busy      out  1       high in every state except IDLE
//   done      out  1       high for exactly the one STOP cycle of each completed frame
// BEHAVIOUR
//   - One clock, synchronous active-high reset. Reset values: state=IDLE, out=0, in_ready=1,
//     busy=0, done=0, shift reg and counters 0.
//   - States: IDLE, PREAMBLE, DATA, PARITY, STOP, GAP. All outputs decoded from state regs.
//   - IDLE: out=0, in_ready=1. Handshake = in_valid&&in_ready at edge: load shreg<=in_data,
//     parity<=^in_data, cnt<=0, go PREAMBLE. No handshake: stay IDLE.
//   - PREAMBLE: out=1 for PREAMBLE_LEN cycles, then DATA.
//   - DATA: out=shreg[DATA_W-1]; shift left by 1 each cycle; DATA_W cycles, then PARITY if
//     PARITY_EN else STOP.
//   - PARITY: out=parity (even: XOR of payload bits), 1 cycle, then STOP.
//   - STOP: out=0, done=1, 1 cycle, then GAP if IDLE_GAP>0 else IDLE.
//   - GAP: out=0, in_ready=0, IDLE_GAP cycles, then IDLE.
//   - Latency: handshake at edge k -> first preamble bit on out in cycle k+1. Frame occupies
//     PREAMBLE_LEN+DATA_W+PARITY_EN+1+IDLE_GAP cycles; in_ready returns in the cycle after.
//     Min one IDLE cycle between frames; no back-to-back acceptance.
//   - in_valid/in_data while busy: ignored, no effect on frame in flight; no buffering.
//   - Counter sized $clog2(max(PREAMBLE_LEN,DATA_W,IDLE_GAP)+1); must not wrap mid-phase.
//   - Reset mid-frame (any state): next cycle IDLE, out=0, done=0; partial frame abandoned,
//     never completed or resumed. rst has priority over handshake in the same cycle.
// TESTING
//   1. rst high 2 cycles, in_valid=1 -> out=0, in_ready=1, busy=0, done=0; no word accepted.
//   2. Defaults, send 8'hA5 -> out=1,1,1,0,1,0,0,1,0,1,0(par),0(stop),0(gap); done high only
//      on stop cycle; in_ready high again exactly 13 cycles after accept edge.
//   3. Defaults, send 8'h01 -> parity bit=1; send 8'hFF -> parity bit=0.
//   4. Mid-frame, drive in_valid=1 with 8'h3C -> ignored; stream of first word unchanged;
//      8'h3C accepted only at first IDLE cycle, then sent intact.
//   5. rst asserted on 4th DATA cycle -> next cycle IDLE, out=0, no done pulse; next word
//      8'h5A transmits cleanly from preamble.
//   6. PARITY_EN=0, IDLE_GAP=0, DATA_W=4, send 4'b1001 -> out=1,1,1,0,0,1,0; frame 7 cycles.

Source files
------------

// File: rtl/serial_frame_tx.sv
// ---------------------------------------------------------------------------
// serial_frame_tx
//
// Purpose:
//   Serial bitstream transmitter. A parallel word accepted over a valid/ready
//   handshake is sent on a single-bit line as one frame:
//     preamble ('1' x PREAMBLE_LEN), payload MSB-first (DATA_W bits),
//     optional even-parity bit, one stop bit ('0'), and IDLE_GAP forced '0'
//     gap cycles. All outputs are decoded from registered state only, so the
//     line never depends combinationally on the inputs.
//
// Parameters:
//   DATA_W        payload width in bits (>= 1)
//   PREAMBLE_LEN  number of '1' preamble bits (>= 1)
//   PARITY_EN     1: append even-parity bit after the payload, 0: omit it
//   IDLE_GAP      number of '0' gap cycles after stop, in_ready low (>= 0)
//
// Ports:
//   clk       in   1       clock, rising edge
//   rst       in   1       synchronous reset, active-high
//   in_valid  in   1       producer presents a word on in_data
//   in_data   in   DATA_W  word to send, sampled only on handshake
//   in_ready  out  1       transmitter can accept a word (IDLE only)
//   out       out  1       serial line
//   busy      out  1       high in every state except IDLE
//   done      out  1       high for the single STOP cycle of each frame
// ---------------------------------------------------------------------------
module serial_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int PREAMBLE_LEN = 2,
  parameter bit PARITY_EN    = 1'b1,
  parameter int IDLE_GAP     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out,
  output logic              busy,
  output logic              done
);

  // -------------------------------------------------------------------------
  // Phase counter sizing. The counter only ever needs to reach the length of
  // the longest multi-cycle phase minus one, so sizing it for max+1 values
  // guarantees it never wraps inside a phase.
  // -------------------------------------------------------------------------
  localparam int MAX_PD  = (PREAMBLE_LEN > DATA_W) ? PREAMBLE_LEN : DATA_W;
  localparam int MAX_LEN = (MAX_PD > IDLE_GAP) ? MAX_PD : IDLE_GAP;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  // With no gap the GAP state is unreachable; pin its terminal count to 0
  // so the constant stays in range.
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

  // -------------------------------------------------------------------------
  // State encoding
  // -------------------------------------------------------------------------
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PREAMBLE = 3'd1;
  localparam logic [2:0] S_DATA     = 3'd2;
  localparam logic [2:0] S_PARITY   = 3'd3;
  localparam logic [2:0] S_STOP     = 3'd4;
  localparam logic [2:0] S_GAP      = 3'd5;

  logic [2:0]        state_q,  state_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [DATA_W-1:0] shreg_q,  shreg_d;
  logic              parity_q, parity_d;

  // The handshake is only possible in IDLE because in_ready is decoded
  // from the IDLE state; anything presented while busy is simply ignored.
  logic accept;
  assign accept = in_valid && in_ready;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    parity_d = parity_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shreg_d  = in_data;
          parity_d = ^in_data;   // even parity: XOR of all payload bits
          cnt_d    = CNT_ZERO;
          state_d  = S_PREAMBLE;
        end
      end

      S_PREAMBLE: begin
        if (cnt_q == PRE_LAST) begin
          cnt_d   = CNT_ZERO;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_DATA: begin
        // The line shows shreg_q[MSB]; shifting left exposes the next bit
        // on the following cycle.
        shreg_d = shreg_q << 1;
        if (cnt_q == DATA_LAST) begin
          cnt_d   = CNT_ZERO;
          state_d = PARITY_EN ? S_PARITY : S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_PARITY: begin
        state_d = S_STOP;
      end

      S_STOP: begin
        cnt_d   = CNT_ZERO;
        state_d = (IDLE_GAP > 0) ? S_GAP : S_IDLE;
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = CNT_ZERO;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        // Unused encodings recover to a clean IDLE.
        cnt_d   = CNT_ZERO;
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers. Reset wins over a same-cycle handshake and abandons any
  // frame in flight; the partial frame is never resumed.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= CNT_ZERO;
      shreg_q  <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      parity_q <= parity_d;
    end
  end

  // -------------------------------------------------------------------------
  // Moore output decode, from registered state only.
  // -------------------------------------------------------------------------
  always_comb begin
    out      = 1'b0;
    in_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_PREAMBLE: out  = 1'b1;
      S_DATA:     out  = shreg_q[DATA_W-1];
      S_PARITY:   out  = parity_q;
      S_STOP:     done = 1'b1;
      S_GAP:      out  = 1'b0;
      default: begin
        out      = 1'b0;
        in_ready = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_serial_frame_tx
//
// Purpose:
//   Directed self-checking bench for serial_frame_tx. Instance A uses the
//   default parameters (8-bit, 2 preamble, parity, 1 gap cycle, 13-cycle
//   frame); instance B uses DATA_W=4, PARITY_EN=0, IDLE_GAP=0 (7-cycle frame).
//   Expected frames are hand-written bit strings, first line bit leftmost.
// ---------------------------------------------------------------------------
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       rst;

  logic       a_valid;
  logic [7:0] a_data;
  logic       a_ready, a_out, a_busy, a_done;

  logic       b_valid;
  logic [3:0] b_data;
  logic       b_ready, b_out, b_busy, b_done;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  serial_frame_tx u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .in_valid (a_valid),
    .in_data  (a_data),
    .in_ready (a_ready),
    .out      (a_out),
    .busy     (a_busy),
    .done     (a_done)
  );

  serial_frame_tx #(
    .DATA_W       (4),
    .PREAMBLE_LEN (2),
    .PARITY_EN    (1'b0),
    .IDLE_GAP     (0)
  ) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .in_valid (b_valid),
    .in_data  (b_data),
    .in_ready (b_ready),
    .out      (b_out),
    .busy     (b_busy),
    .done     (b_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready_a;
    for (int i = 0; i < 40 && !a_ready; i++) tick();
    check_eq("a_ready_wait", 32'(a_ready), 32'd1);
  endtask

  task automatic wait_ready_b;
    for (int i = 0; i < 40 && !b_ready; i++) tick();
    check_eq("b_ready_wait", 32'(b_ready), 32'd1);
  endtask

  // Capture 13 line cycles of instance A starting at the current cycle.
  task automatic capture_a(output logic [12:0] f, output logic [12:0] d,
                           output logic [12:0] r, output logic [12:0] bz);
    for (int i = 0; i < 13; i++) begin
      f[12-i]  = a_out;
      d[12-i]  = a_done;
      r[12-i]  = a_ready;
      bz[12-i] = a_busy;
      tick();
    end
  endtask

  task automatic check_frame_a(input string tag, input logic [7:0] w,
                               input logic [12:0] exp_f, input logic [12:0] f,
                               input logic [12:0] d, input logic [12:0] r,
                               input logic [12:0] bz);
    check_eq({tag, "_line"},  32'(f),  32'(exp_f));
    check_eq({tag, "_done"},  32'(d),  32'h0002);
    check_eq({tag, "_ready"}, 32'(r),  32'h0000);
    check_eq({tag, "_busy"},  32'(bz), 32'h1FFF);
    $display("frame A word=%02h line=%013b done=%013b", w, f, d);
  endtask

  // Full single-word transaction on A: handshake, capture, then in_ready
  // must be back exactly 13 cycles after the accept edge.
  task automatic send_a(input string tag, input logic [7:0] w, input logic [12:0] exp_f);
    logic [12:0] f, d, r, bz;
    wait_ready_a();
    a_valid = 1'b1;
    a_data  = w;
    tick();
    a_valid = 1'b0;
    a_data  = 8'h00;
    capture_a(f, d, r, bz);
    check_frame_a(tag, w, exp_f, f, d, r, bz);
    check_eq({tag, "_ready_back"}, 32'(a_ready), 32'd1);
  endtask

  initial begin
    logic [12:0] f, d, r, bz;
    logic [6:0]  fb, db;
    logic        any_activity;

    // ---- 1: reset with in_valid held high --------------------------------
    rst     = 1'b1;
    a_valid = 1'b1;
    a_data  = 8'hFF;
    b_valid = 1'b1;
    b_data  = 4'hF;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("rst_out",   32'(a_out),   32'd0);
      check_eq("rst_ready", 32'(a_ready), 32'd1);
      check_eq("rst_busy",  32'(a_busy),  32'd0);
      check_eq("rst_done",  32'(a_done),  32'd0);
    end
    rst     = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
    check_eq("post_rst_busy_a", 32'(a_busy), 32'd0);
    check_eq("post_rst_busy_b", 32'(b_busy), 32'd0);
    $display("reset applied with in_valid high, no word accepted");

    // ---- 2: 8'hA5 -> 11 10100101 0 0 0 ------------------------------------
    send_a("a5", 8'hA5, 13'b11_10100101_0_0_0);

    // ---- 3: parity polarity -----------------------------------------------
    send_a("p01", 8'h01, 13'b11_00000001_1_0_0);
    send_a("pff", 8'hFF, 13'b11_11111111_0_0_0);

    // ---- 4: word presented while busy is ignored, then taken at IDLE ------
    wait_ready_a();
    a_valid = 1'b1;
    a_data  = 8'hA5;
    tick();
    a_data  = 8'h3C;               // in_valid stays high through the frame
    capture_a(f, d, r, bz);
    check_frame_a("busy_a5", 8'hA5, 13'b11_10100101_0_0_0, f, d, r, bz);
    check_eq("busy_ready_back", 32'(a_ready), 32'd1);
    tick();                         // 3C accepted on this first IDLE edge
    a_valid = 1'b0;
    a_data  = 8'h00;
    capture_a(f, d, r, bz);
    check_frame_a("late_3c", 8'h3C, 13'b11_00111100_0_0_0, f, d, r, bz);

    // ---- 5: reset on 4th DATA cycle ---------------------------------------
    wait_ready_a();
    a_valid = 1'b1;
    a_data  = 8'hA5;
    tick();
    a_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();   // now in DATA bit 3 (A5 -> '0')
    check_eq("mid_busy", 32'(a_busy), 32'd1);
    check_eq("mid_out",  32'(a_out),  32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_out",   32'(a_out),   32'd0);
    check_eq("abort_ready", 32'(a_ready), 32'd1);
    check_eq("abort_busy",  32'(a_busy),  32'd0);
    check_eq("abort_done",  32'(a_done),  32'd0);
    any_activity = 1'b0;
    for (int i = 0; i < 16; i++) begin
      any_activity = any_activity | a_out | a_done | a_busy;
      tick();
    end
    check_eq("abort_quiet", 32'(any_activity), 32'd0);
    $display("reset mid-frame, partial A5 abandoned");
    send_a("after_abort", 8'h5A, 13'b11_01011010_0_0_0);

    // ---- 6: no parity, no gap, 4-bit 1001 -> 1,1,1,0,0,1,0 ----------------
    wait_ready_b();
    b_valid = 1'b1;
    b_data  = 4'b1001;
    tick();
    b_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      fb[6-i] = b_out;
      db[6-i] = b_done;
      tick();
    end
    check_eq("b_line",       32'(fb),      32'(7'b1110010));
    check_eq("b_done",       32'(db),      32'(7'b0000001));
    check_eq("b_ready_back", 32'(b_ready), 32'd1);
    $display("frame B word=%01h line=%07b done=%07b", 4'b1001, fb, db);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
